sliding_dft_core: RTL and testbench

- Sliding DFT engine for the waterfall display path.
- Each accepted input sample updates LIMIT_BINS complex frequency bins using the recurrence X_k <- (X_k + delta) * W^k. Here delta = newest sample - oldest sample and W = e^(j*2*pi/FREQ_BINS).
- Contains a twiddle ROM, four registered 16x16 signed multipliers and a magnitude approximator.
- Bin magnitudes are read out one address at a time for the display.

---
 rtl/sliding_dft_core_if.sv | 26 ++
 rtl/sliding_dft_core.sv | 235 +++++++++++++++++++++++
 tb/tb_sliding_dft_core.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sliding_dft_core_if.sv
// Sample/start/read handshake and magnitude readout bus
// for the sliding DFT engine.
interface sliding_dft_core_if #(
    parameter int DATA_W     = 8,
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = 32
);
    localparam int AW = $clog2(LIMIT_BINS);

    logic [DATA_W-1:0] sample;
    logic              start;
    logic              read;
    logic [AW-1:0]     bin_addr;
    logic [FREQ_W-1:0] bin_out;
    logic              ready;

    modport master (
        output sample, start, read, bin_addr,
        input  bin_out, ready
    );

    modport slave (
        input  sample, start, read, bin_addr,
        output bin_out, ready
    );
endinterface

// File: rtl/sliding_dft_core.sv
// Sliding DFT: per-sample update of LIMIT_BINS complex bins
// with X_k <- (X_k + delta) * W^k, plus magnitude readout.
module sliding_dft_core #(
    parameter int DATA_W     = 8,
    parameter int FREQ_BINS  = 64,
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = 32
) (
    input logic               clk,
    input logic               reset,
    sliding_dft_core_if.slave bus
);
    localparam int AW = $clog2(LIMIT_BINS);
    localparam int IW = $clog2(FREQ_BINS);
    localparam int PW = 2 * FREQ_W;
    localparam logic [AW-1:0] LAST_TW  = AW'(LIMIT_BINS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FREQ_BINS - 1);
    localparam logic signed [PW:0] SMAX =
        {{(PW-FREQ_W+2){1'b0}}, {(FREQ_W-1){1'b1}}};
    localparam logic signed [PW:0] SMIN =
        {{(PW-FREQ_W+2){1'b1}}, {(FREQ_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_WAIT, S_START, S_CALC_1, S_CALC_2,
        S_CALC_3, S_FINISH, S_READ
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0]        samples [FREQ_BINS];
    logic signed [FREQ_W-1:0] bin_re  [LIMIT_BINS];
    logic signed [FREQ_W-1:0] bin_im  [LIMIT_BINS];
    logic [IW-1:0]            sample_index;
    logic [AW-1:0]            tw_addr, tw_nxt;
    logic signed [DATA_W:0]   delta;
    logic signed [FREQ_W-1:0] tw_re, tw_im;
    logic signed [PW-1:0]     p_rr, p_ii, p_ri, p_ir;
    logic signed [FREQ_W-1:0] rd_re, rd_im;
    logic [FREQ_W-1:0]        bin_out_q;

    function automatic logic signed [FREQ_W-1:0] sat(
        input logic signed [PW:0] v
    );
        if (v > SMAX) return SMAX[FREQ_W-1:0];
        if (v < SMIN) return SMIN[FREQ_W-1:0];
        return v[FREQ_W-1:0];
    endfunction

    // Quarter-wave of round(127*sin(2*pi*j/64)), j = 0..16.
    function automatic logic [6:0] qsin(input logic [4:0] j);
        unique case (j)
            5'd0:    return 7'd0;
            5'd1:    return 7'd12;
            5'd2:    return 7'd25;
            5'd3:    return 7'd37;
            5'd4:    return 7'd49;
            5'd5:    return 7'd60;
            5'd6:    return 7'd71;
            5'd7:    return 7'd81;
            5'd8:    return 7'd90;
            5'd9:    return 7'd98;
            5'd10:   return 7'd106;
            5'd11:   return 7'd112;
            5'd12:   return 7'd117;
            5'd13:   return 7'd122;
            5'd14:   return 7'd125;
            5'd15:   return 7'd126;
            default: return 7'd127;
        endcase
    endfunction

    // Full-circle sine for a 64-point table via quadrant symmetry.
    function automatic logic signed [FREQ_W-1:0] tw_sin(
        input logic [5:0] k
    );
        logic [4:0]               j;
        logic signed [FREQ_W-1:0] v;
        j = (k[4:0] > 5'd16) ? 5'(6'd32 - {1'b0, k[4:0]}) : k[4:0];
        v = {{(FREQ_W-7){1'b0}}, qsin(j)};
        return k[5] ? -v : v;
    endfunction

    function automatic logic signed [FREQ_W-1:0] tw_cos(
        input logic [5:0] k
    );
        return tw_sin(k + 6'd16);
    endfunction

    // Multiplier operands; delta only enters the real part.
    logic signed [FREQ_W-1:0] cur_re, op_re, op_im;
    logic signed [PW:0]       a_sum;
    logic signed [PW-1:0]     op_re_x, op_im_x, tw_re_x, tw_im_x;

    assign cur_re  = bin_re[tw_addr];
    assign a_sum   = {{(PW+1-FREQ_W){cur_re[FREQ_W-1]}}, cur_re}
                   + {{(PW-DATA_W){delta[DATA_W]}}, delta};
    assign op_re   = sat(a_sum);
    assign op_im   = bin_im[tw_addr];
    assign op_re_x = {{FREQ_W{op_re[FREQ_W-1]}}, op_re};
    assign op_im_x = {{FREQ_W{op_im[FREQ_W-1]}}, op_im};
    assign tw_re_x = {{FREQ_W{tw_re[FREQ_W-1]}}, tw_re};
    assign tw_im_x = {{FREQ_W{tw_im[FREQ_W-1]}}, tw_im};

    // Complex product recombination, scaled back by the 127 gain.
    logic signed [PW:0]       sum_re, sum_im, sh_re, sh_im;
    logic signed [FREQ_W-1:0] new_re, new_im;

    assign sum_re = {p_rr[PW-1], p_rr} - {p_ii[PW-1], p_ii};
    assign sum_im = {p_ri[PW-1], p_ri} + {p_ir[PW-1], p_ir};
    assign sh_re  = sum_re >>> 7;
    assign sh_im  = sum_im >>> 7;
    assign new_re = sat(sh_re);
    assign new_im = sat(sh_im);

    // Magnitude approximation of the registered readout pair.
    logic [FREQ_W-1:0] abs_r, abs_i, mx, mn, mag;
    logic [FREQ_W:0]   m_sum;

    always_comb begin
        abs_r = rd_re[FREQ_W-1] ? -rd_re : rd_re;
        abs_i = rd_im[FREQ_W-1] ? -rd_im : rd_im;
        mx    = (abs_r > abs_i) ? abs_r : abs_i;
        mn    = (abs_r > abs_i) ? abs_i : abs_r;
        m_sum = {1'b0, mx} + {1'b0, (mn >> 1)};
        mag   = m_sum[FREQ_W] ? '1 : m_sum[FREQ_W-1:0];
    end

    assign bus.ready   = (state == S_WAIT);
    assign bus.bin_out = bin_out_q;

    // Next-state and twiddle address sequencing.
    always_comb begin
        state_nxt = state;
        tw_nxt    = tw_addr;
        unique case (state)
            S_WAIT: begin
                if (bus.read)       state_nxt = S_READ;
                else if (bus.start) state_nxt = S_START;
            end
            S_START: begin
                tw_nxt    = '0;
                state_nxt = S_CALC_1;
            end
            S_CALC_1: state_nxt = S_CALC_2;
            S_CALC_2: state_nxt = S_CALC_3;
            S_CALC_3: begin
                if (tw_addr == LAST_TW) begin
                    tw_nxt    = '0;
                    state_nxt = S_FINISH;
                end else begin
                    tw_nxt    = tw_addr + 1'b1;
                    state_nxt = S_CALC_1;
                end
            end
            S_FINISH: state_nxt = S_WAIT;
            S_READ:   if (!bus.read) state_nxt = S_WAIT;
            default:  state_nxt = S_WAIT;
        endcase
    end

    // State and twiddle address registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_WAIT;
            tw_addr <= '0;
        end else begin
            state   <= state_nxt;
            tw_addr <= tw_nxt;
        end
    end

    // ROM addressed by next tw_addr so data lines up in CALC_1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tw_re <= '0;
            tw_im <= '0;
            p_rr  <= '0;
            p_ii  <= '0;
            p_ri  <= '0;
            p_ir  <= '0;
        end else begin
            tw_re <= tw_cos(6'(tw_nxt));
            tw_im <= tw_sin(6'(tw_nxt));
            p_rr  <= op_re_x * tw_re_x;
            p_ii  <= op_im_x * tw_im_x;
            p_ri  <= op_re_x * tw_im_x;
            p_ir  <= op_im_x * tw_re_x;
        end
    end

    // Sample history, delta capture and history pointer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FREQ_BINS; i++) samples[i] <= '0;
            delta        <= '0;
            sample_index <= '0;
        end else begin
            if (state == S_START) begin
                delta <= {1'b0, bus.sample}
                       - {1'b0, samples[sample_index]};
                samples[sample_index] <= bus.sample;
            end
            if (state == S_FINISH) begin
                sample_index <= (sample_index == LAST_IDX)
                              ? '0 : sample_index + 1'b1;
            end
        end
    end

    // Bin register write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LIMIT_BINS; i++) begin
                bin_re[i] <= '0;
                bin_im[i] <= '0;
            end
        end else if (state == S_CALC_2) begin
            bin_re[tw_addr] <= new_re;
            bin_im[tw_addr] <= new_im;
        end
    end

    // Two-stage magnitude readout pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_re     <= '0;
            rd_im     <= '0;
            bin_out_q <= '0;
        end else if (state == S_READ) begin
            rd_re     <= bin_re[bus.bin_addr];
            rd_im     <= bin_im[bus.bin_addr];
            bin_out_q <= mag >> 1;
        end
    end
endmodule

// File: tb/tb_sliding_dft_core.sv
// Directed bench for sliding_dft_core: impulse bins,
// streaming readout, busy guard, reset abort, history wrap.
module tb_sliding_dft_core;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sliding_dft_core_if bus ();

    sliding_dft_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.read     = 1'b0;
        bus.sample   = '0;
        bus.bin_addr = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_update(input logic [7:0] s,
                              output int cyc);
        bus.sample = s;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.ready && cyc < 500) begin
            cyc++;
            tick();
        end
    endtask

    task automatic read_bin(input int addr, output int val);
        bus.read     = 1'b1;
        bus.bin_addr = 5'(addr);
        tick();
        tick();
        bus.read = 1'b0;
        tick();
        val = int'(bus.bin_out);
    endtask

    function automatic int tw(input int k, input bit is_sin);
        real a;
        a = 2.0 * 3.14159265358979 * k / 64.0;
        return $rtoi($floor(127.0 * (is_sin ? $sin(a) : $cos(a))
                            + 0.5));
    endfunction

    function automatic int mag_out(input int r, input int i);
        int ar, ai, mx, mn;
        ar = (r < 0) ? -r : r;
        ai = (i < 0) ? -i : i;
        mx = (ar > ai) ? ar : ai;
        mn = (ar > ai) ? ai : ar;
        return (mx + (mn >>> 1)) >>> 1;
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v, cyc, r;
        int exp_s [32];

        // Reset state
        do_reset();
        check("rst_ready", bus.ready, 1);
        check("rst_bin_out", bus.bin_out, 0);
        read_bin(5, v);
        check("rst_bin5", v, 0);

        // Single impulse of 100 from reset
        run_update(8'd100, cyc);
        check("imp_len", cyc, 98);
        read_bin(0, v);
        check("imp_bin0", v, 49);
        read_bin(8, v);
        check("imp_bin8", v, 52);
        read_bin(16, v);
        check("imp_bin16", v, 49);
        check("imp_ready", bus.ready, 1);

        // Streaming readout over all bins
        for (int k = 0; k < 32; k++) begin
            exp_s[k] = mag_out((100 * tw(k, 0)) >>> 7,
                               (100 * tw(k, 1)) >>> 7);
        end
        bus.read     = 1'b1;
        bus.bin_addr = '0;
        tick();
        check("stream_busy", bus.ready, 0);
        for (int j = 0; j < 34; j++) begin
            if (j >= 2)
                check($sformatf("stream_bin%0d", j - 2),
                      bus.bin_out, exp_s[j-2]);
            bus.bin_addr = (j < 32) ? 5'(j) : 5'd0;
            tick();
        end
        bus.read = 1'b0;
        tick();
        check("stream_exit", bus.ready, 1);

        // Start/read pulses during an update are ignored
        do_reset();
        bus.sample = 8'd100;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.ready && cyc < 500) begin
            cyc++;
            if (cyc == 20) begin
                bus.start    = 1'b1;
                bus.read     = 1'b1;
                bus.sample   = 8'd200;
                bus.bin_addr = 5'd3;
            end else if (cyc == 23) begin
                bus.start = 1'b0;
                bus.read  = 1'b0;
            end
            tick();
        end
        check("busy_len", cyc, 98);
        repeat (5) tick();
        check("busy_no_retrigger", bus.ready, 1);
        read_bin(0, v);
        check("busy_bin0", v, 49);
        run_update(8'd100, cyc);
        check("second_len", cyc, 98);
        read_bin(0, v);
        check("second_bin0", v, 98);
        read_bin(16, v);
        check("second_bin16", v, 74);

        // Reset in the middle of an update
        bus.sample = 8'd100;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (40) tick();
        check("mid_busy", bus.ready, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", bus.ready, 1);
        check("mid_rst_bin_out", bus.bin_out, 0);
        tick();
        reset = 1'b0;
        tick();
        read_bin(0, v);
        check("mid_rst_bin0", v, 0);
        read_bin(16, v);
        check("mid_rst_bin16", v, 0);

        // History wrap: 65 samples of 50, last has delta 0
        do_reset();
        r = 0;
        for (int n = 0; n < 65; n++) begin
            run_update(8'd50, cyc);
            check($sformatf("wrap_len%0d", n), cyc, 98);
            r = ((r + ((n < 64) ? 50 : 0)) * 127) >>> 7;
        end
        read_bin(0, v);
        check("wrap_bin0", v, r >>> 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
